// File: rtl/fp16_add_arbiter_if.sv
// Requester and shared-adder signal bundle for fp16_add_arbiter.
// slave is the arbiter side; master is the requester/adder side.
interface fp16_add_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic [NREQ-1:0]    req_sub;
  logic               add_valid;
  logic [15:0]        add_a;
  logic [15:0]        add_b;
  logic               add_sub;
  logic [15:0]        add_result;
  logic [NREQ-1:0]    rsp_valid;
  logic [15:0]        rsp_data;
  logic [IDW-1:0]     gnt_id;

  modport slave (
    input  req_valid, req_a, req_b, req_sub, add_result,
    output req_ready, add_valid, add_a, add_b, add_sub,
    output rsp_valid, rsp_data, gnt_id
  );

  modport master (
    output req_valid, req_a, req_b, req_sub, add_result,
    input  req_ready, add_valid, add_a, add_b, add_sub,
    input  rsp_valid, rsp_data, gnt_id
  );
endinterface

// File: rtl/fp16_add_arbiter.sv
// Round-robin sharing of one pipelined FP16 adder among NREQ requesters,
// with a tag pipeline routing each result back to its issuer.
module fp16_add_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int IDW  = 2
) (
  input logic clk,
  input logic rst,
  fp16_add_arbiter_if.slave bus
);
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  win_nxt;
  logic [IDW-1:0]  idx;
  logic            found;
  logic            hs;
  logic [NREQ-1:0] ready;

  logic            add_valid;
  logic [15:0]     add_a;
  logic [15:0]     add_b;
  logic            add_sub;
  logic [IDW-1:0]  gnt_id;
  logic [NREQ-1:0] rsp_valid;
  logic [15:0]     rsp_data;

  logic [LAT-1:0]  tag_v;
  logic [IDW-1:0]  tag_id [LAT];

  // First valid requester at or after ptr wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (found && !rst) ready[win] = 1'b1;
  end

  assign hs      = found & ~rst;
  assign win_nxt = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      add_valid <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      add_sub   <= 1'b0;
      gnt_id    <= '0;
    end else begin
      add_valid <= hs;
      if (hs) begin
        ptr     <= win_nxt;
        add_a   <= bus.req_a[int'(win)*16 +: 16];
        add_b   <= bus.req_b[int'(win)*16 +: 16];
        add_sub <= bus.req_sub[win];
        gnt_id  <= win;
      end
    end
  end

  // Stage 0 captures the issue registers, so the last stage lines up
  // with the cycle add_result is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      tag_v[0] <= add_valid;
      for (int i = 1; i < LAT; i++) tag_v[i] <= tag_v[i-1];
      if (tag_v[LAT-1]) begin
        rsp_valid <= NREQ'(1) << tag_id[LAT-1];
        rsp_data  <= bus.add_result;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_id[0] <= gnt_id;
    for (int i = 1; i < LAT; i++) tag_id[i] <= tag_id[i-1];
  end

  assign bus.req_ready = ready;
  assign bus.add_valid = add_valid;
  assign bus.add_a     = add_a;
  assign bus.add_b     = add_b;
  assign bus.add_sub   = add_sub;
  assign bus.gnt_id    = gnt_id;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Bench for fp16_add_arbiter: stub LAT-cycle adder plus a response
// scoreboard keyed on requester id, data and arrival cycle.
module tb_fp16_add_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int IDW  = 2;

  typedef struct {
    logic [IDW-1:0] id;
    logic [15:0]    data;
    int             cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_fail;
  logic [15:0] last_a;
  logic [15:0] pipe [LAT];
  exp_t sbq [$];

  fp16_add_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  fp16_add_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in adder: exact results for the known FP16 pairs, a
  // distinctive scramble for anything else.
  function automatic logic [15:0] fadd(input logic [15:0] a,
                                       input logic [15:0] b,
                                       input logic s);
    if (a == 16'h3C00 && b == 16'h4000 && !s) return 16'h4200;
    if (a == 16'h4200 && b == 16'h3C00 && s) return 16'h4000;
    return a ^ {b[7:0], b[15:8]} ^ {16{s}};
  endfunction

  always @(posedge clk) begin
    pipe[0] <= fadd(bus.add_a, bus.add_b, bus.add_sub);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.add_result = pipe[LAT-1];

  task automatic set_req(input int id, input logic [15:0] a,
                         input logic [15:0] b, input logic s);
    bus.req_a[id*16 +: 16] = a;
    bus.req_b[id*16 +: 16] = b;
    bus.req_sub[id]        = s;
  endtask

  task automatic push(input int id, input logic [15:0] a,
                      input logic [15:0] b, input logic s);
    exp_t e;
    e.id   = IDW'(id);
    e.data = fadd(a, b, s);
    e.cyc  = cyc + LAT + 2;
    sbq.push_back(e);
  endtask

  // Advance to the next falling edge and score any response.
  task automatic step();
    exp_t e;
    logic [NREQ-1:0] oh;
    @(negedge clk);
    if (sbq.size() != 0 && sbq[0].cyc < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL rsp_missing: id %0d due cycle %0d, none by cycle %0d",
               sbq[0].id, sbq[0].cyc, cyc);
      void'(sbq.pop_front());
    end
    if (bus.rsp_valid !== '0) begin
      n_chk++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: rsp_valid %b data %h at cycle %0d, none required",
                 bus.rsp_valid, bus.rsp_data, cyc);
      end else begin
        e  = sbq.pop_front();
        oh = NREQ'(1) << e.id;
        if (bus.rsp_valid !== oh || bus.rsp_data !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL rsp: got %b/%h at cycle %0d, required %b/%h at cycle %0d",
                   bus.rsp_valid, bus.rsp_data, cyc, oh, e.data, e.cyc);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    for (int i = 0; i < NREQ; i++) set_req(i, 16'h1111 * i, 16'h2222, 1'b1);
    step();
    step();
    n_chk++;
    if (bus.req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b required 0000", bus.req_ready);
    end
    n_chk++;
    if ({bus.add_valid, bus.add_a, bus.add_b, bus.add_sub, bus.gnt_id} !== '0) begin
      n_fail++;
      $display("FAIL reset_issue: got v%b a%h b%h s%b g%0d required all 0",
               bus.add_valid, bus.add_a, bus.add_b, bus.add_sub, bus.gnt_id);
    end
    n_chk++;
    if (bus.rsp_valid !== '0 || bus.rsp_data !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: got %b/%h required 0000/0000",
               bus.rsp_valid, bus.rsp_data);
    end
    rst = 1'b0;
    bus.req_valid = '0;
  endtask

  task automatic test_all_four();
    logic [15:0] a;
    logic [15:0] b;
    logic [NREQ-1:0] want;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        n_chk++;
        if (bus.add_valid !== 1'b1 || bus.gnt_id !== IDW'((k - 1) % NREQ)) begin
          n_fail++;
          $display("FAIL rr_issue: got v%b g%0d required v1 g%0d",
                   bus.add_valid, bus.gnt_id, (k - 1) % NREQ);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        a = 16'($urandom);
        b = 16'($urandom);
        set_req(i, a, b, i[0]);
      end
      bus.req_valid = '1;
      #1;
      want = NREQ'(1) << (k % NREQ);
      n_chk++;
      if (bus.req_ready !== want) begin
        n_fail++;
        $display("FAIL rr_grant %0d: got %b required %b", k, bus.req_ready, want);
      end
      push(k % NREQ, bus.req_a[(k % NREQ)*16 +: 16],
           bus.req_b[(k % NREQ)*16 +: 16], bus.req_sub[k % NREQ]);
      step();
    end
    bus.req_valid = '0;
    n_chk++;
    if (bus.add_valid !== 1'b1 || bus.gnt_id !== 2'd3) begin
      n_fail++;
      $display("FAIL rr_last: got v%b g%0d required v1 g3", bus.add_valid, bus.gnt_id);
    end
    step();
    n_chk++;
    if (bus.add_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_idle: add_valid %b required 0", bus.add_valid);
    end
    repeat (6) step();
  endtask

  task automatic test_single();
    set_req(1, 16'h3C00, 16'h4000, 1'b0);
    bus.req_valid = 4'b0010;
    #1;
    n_chk++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL single_ready: got %b required 0010", bus.req_ready);
    end
    push(1, 16'h3C00, 16'h4000, 1'b0);
    step();
    bus.req_valid = '0;
    n_chk++;
    if (bus.add_valid !== 1'b1 || bus.add_a !== 16'h3C00 ||
        bus.add_b !== 16'h4000 || bus.add_sub !== 1'b0 || bus.gnt_id !== 2'd1) begin
      n_fail++;
      $display("FAIL single_issue: got v%b a%h b%h s%b g%0d required v1 a3c00 b4000 s0 g1",
               bus.add_valid, bus.add_a, bus.add_b, bus.add_sub, bus.gnt_id);
    end
    repeat (5) step();
  endtask

  task automatic test_sub();
    set_req(0, 16'h4200, 16'h3C00, 1'b1);
    bus.req_valid = 4'b0001;
    #1;
    n_chk++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL sub_ready: got %b required 0001", bus.req_ready);
    end
    push(0, 16'h4200, 16'h3C00, 1'b1);
    step();
    bus.req_valid = '0;
    n_chk++;
    if (bus.add_valid !== 1'b1 || bus.add_sub !== 1'b1 || bus.add_a !== 16'h4200) begin
      n_fail++;
      $display("FAIL sub_issue: got v%b s%b a%h required v1 s1 a4200",
               bus.add_valid, bus.add_sub, bus.add_a);
    end
    repeat (5) step();
  endtask

  task automatic test_fairness();
    set_req(2, 16'h1234, 16'h5678, 1'b0);
    bus.req_valid = 4'b0100;
    #1;
    n_chk++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL fair_r2: got %b required 0100", bus.req_ready);
    end
    push(2, 16'h1234, 16'h5678, 1'b0);
    step();
    set_req(0, 16'h0A0A, 16'h0B0B, 1'b0);
    set_req(3, 16'h0C0C, 16'h0D0D, 1'b1);
    bus.req_valid = 4'b1001;
    #1;
    n_chk++;
    if (bus.req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL fair_r3: got %b required 1000", bus.req_ready);
    end
    push(3, 16'h0C0C, 16'h0D0D, 1'b1);
    step();
    bus.req_valid = 4'b0001;
    #1;
    n_chk++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL fair_r0: got %b required 0001", bus.req_ready);
    end
    push(0, 16'h0A0A, 16'h0B0B, 1'b0);
    step();
    bus.req_valid = '0;
    repeat (6) step();
  endtask

  task automatic test_reset_midflight();
    set_req(1, 16'h5555, 16'h6666, 1'b0);
    set_req(2, 16'h7777, 16'h8888, 1'b1);
    bus.req_valid = 4'b0010;
    #1;
    n_chk++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL mid_g1: got %b required 0010", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b0100;
    #1;
    n_chk++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_g2: got %b required 0100", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++;
    if (bus.add_valid !== 1'b0 || bus.gnt_id !== '0 || bus.rsp_valid !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got v%b g%0d r%b required v0 g0 r0000",
               bus.add_valid, bus.gnt_id, bus.rsp_valid);
    end
    set_req(1, 16'h3C00, 16'h4000, 1'b0);
    set_req(3, 16'h9999, 16'hAAAA, 1'b0);
    bus.req_valid = 4'b1010;
    #1;
    n_chk++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL mid_ptr: got %b required 0010", bus.req_ready);
    end
    push(1, 16'h3C00, 16'h4000, 1'b0);
    last_a = 16'h3C00;
    step();
    bus.req_valid = '0;
    repeat (6) step();
  endtask

  task automatic test_idle_drop();
    for (int k = 0; k < 10; k++) begin
      step();
      n_chk++;
      if (bus.add_valid !== 1'b0 || bus.rsp_valid !== '0 ||
          bus.add_a !== last_a || bus.gnt_id !== 2'd1 || bus.rsp_data !== 16'h4200) begin
        n_fail++;
        $display("FAIL idle %0d: got v%b r%b a%h g%0d d%h required v0 r0000 a%h g1 d4200",
                 k, bus.add_valid, bus.rsp_valid, bus.add_a, bus.gnt_id,
                 bus.rsp_data, last_a);
      end
    end
    set_req(2, 16'hBEEF, 16'hCAFE, 1'b0);
    set_req(3, 16'hDEAD, 16'hF00D, 1'b1);
    bus.req_valid = 4'b1100;
    #1;
    n_chk++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL drop_grant: got %b required 0100", bus.req_ready);
    end
    push(2, 16'hBEEF, 16'hCAFE, 1'b0);
    step();
    bus.req_valid = '0;
    #1;
    n_chk++;
    if (bus.req_ready !== '0 || bus.gnt_id !== 2'd2 || bus.add_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_after: got r%b g%0d v%b required r0000 g2 v1",
               bus.req_ready, bus.gnt_id, bus.add_valid);
    end
    repeat (8) step();
  endtask

  initial begin
    cyc    = 0;
    n_chk  = 0;
    n_fail = 0;
    last_a = '0;
    rst    = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = '0;
    test_reset();
    test_all_four();
    test_single();
    test_sub();
    test_fairness();
    test_reset_midflight();
    test_idle_drop();
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
